mem_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Accepts instructions whose data-SRAM request was already address-accepted by execute, and waits for the matching data_ok response.
- Aligns and extends load data, selects the final writeback result, and forwards register results and exception status to earlier stages.
- Discards stale responses belonging to instructions cancelled by a writeback flush.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_load_align.sv | 29 ++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: load-type encoding,
// bus widths and exception codes.
package mem_stage_pkg;

   localparam int unsigned MEM_SIDE_W  = 160;
   localparam int unsigned MEM_TO_EX_W = 2;
   localparam int unsigned FWD_ADDR_W  = 5;
   localparam int unsigned FWD_DATA_W  = 32;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_PIL = 6'h01;
   localparam logic [5:0] ECODE_PIS = 6'h02;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0b;
   localparam logic [5:0] ECODE_BRK = 6'h0c;
   localparam logic [5:0] ECODE_INE = 6'h0d;

   typedef enum logic [1:0] {
      LdW = 2'd0,
      LdB = 2'd1,
      LdH = 2'd2
   } ld_size_e;

   typedef struct packed {
      ld_size_e size;
      logic     u;
   } ld_type_t;

   function automatic ld_type_t ld_decode(input logic b, input logic h, input logic u);
      ld_type_t t;
      t.u    = u;
      t.size = b ? LdB : (h ? LdH : LdW);
      return t;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Shifts the read word down to the addressed byte/halfword and sign- or
// zero-extends it to 32 bits.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic        b,
   input  logic        h,
   input  logic        u,
   output logic [31:0] data
);

   logic [31:0] sh;
   ld_type_t    lt;

   assign sh = rdata >> {addr_lo, 3'b000};
   assign lt = ld_decode(b, h, u);

   always_comb begin
      data = sh;
      unique case (lt.size)
         LdB:     data = {{24{~lt.u & sh[7]}}, sh[7:0]};
         LdH:     data = {{16{~lt.u & sh[15]}}, sh[15:0]};
         default: data = sh;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, buffers it if
// writeback stalls, and drops responses owned by flushed instructions.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned SIDE_W = MEM_SIDE_W,
   parameter int unsigned DISC_W = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   ex_to_mem_valid,
   output logic                   mem_allowin,
   input  logic [31:0]            ex_pc,
   input  logic                   ex_rf_we,
   input  logic [4:0]             ex_rf_waddr,
   input  logic [31:0]            ex_alu_result,
   input  logic                   ex_res_from_mem,
   input  logic                   ex_mem_req,
   input  logic [1:0]             ex_addr_lo,
   input  logic                   ex_ld_b,
   input  logic                   ex_ld_h,
   input  logic                   ex_ld_u,
   input  logic                   ex_excep_en,
   input  logic                   ex_ertn_flush,
   input  logic [SIDE_W-1:0]      ex_side,
   input  logic                   data_sram_data_ok,
   input  logic [31:0]            data_sram_rdata,
   input  logic                   flush,
   input  logic                   wb_allowin,
   output logic                   mem_to_wb_valid,
   output logic [31:0]            mem_pc,
   output logic                   mem_rf_we,
   output logic [4:0]             mem_rf_waddr,
   output logic [31:0]            mem_final_result,
   output logic                   mem_excep_en,
   output logic                   mem_ertn_flush,
   output logic [SIDE_W-1:0]      mem_side,
   output logic                   mem_fwd_we,
   output logic [FWD_ADDR_W-1:0]  mem_fwd_waddr,
   output logic [FWD_DATA_W-1:0]  mem_fwd_data,
   output logic                   mem_fwd_block,
   output logic [MEM_TO_EX_W-1:0] mem_to_ex_bus
);

   localparam logic [DISC_W-1:0] DiscMax = '1;

   logic              mem_valid;
   logic [31:0]       mem_alu_result;
   logic              mem_res_from_mem;
   logic              mem_mem_req;
   logic [1:0]        mem_addr_lo;
   logic              mem_ld_b, mem_ld_h, mem_ld_u;
   logic              rbuf_valid;
   logic [31:0]       rbuf_data;
   logic [DISC_W-1:0] disc_cnt, disc_cnt_d;
   logic              own_ok, ready_go, leave, rbuf_set, disc_inc, disc_dec;
   logic [31:0]       rdata_sel, load_data;

   // A response only belongs to us once every stale one has been swallowed.
   assign own_ok          = data_sram_data_ok & (disc_cnt == '0);
   assign ready_go        = ~mem_mem_req | rbuf_valid | own_ok;
   assign leave           = mem_valid & ready_go & wb_allowin;
   assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
   assign mem_to_wb_valid = mem_valid & ready_go & ~flush;

   assign rbuf_set = mem_valid & mem_mem_req & ~rbuf_valid & own_ok & ~wb_allowin;
   assign disc_inc = flush & mem_valid & mem_mem_req & ~rbuf_valid & ~own_ok;
   assign disc_dec = data_sram_data_ok & (disc_cnt != '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_valid <= 1'b0;
      end else if (flush) begin
         mem_valid <= 1'b0;
      end else if (mem_allowin) begin
         mem_valid <= ex_to_mem_valid;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_pc           <= '0;
         mem_rf_we        <= 1'b0;
         mem_rf_waddr     <= '0;
         mem_alu_result   <= '0;
         mem_res_from_mem <= 1'b0;
         mem_mem_req      <= 1'b0;
         mem_addr_lo      <= '0;
         mem_ld_b         <= 1'b0;
         mem_ld_h         <= 1'b0;
         mem_ld_u         <= 1'b0;
         mem_excep_en     <= 1'b0;
         mem_ertn_flush   <= 1'b0;
         mem_side         <= '0;
      end else if (ex_to_mem_valid && mem_allowin) begin
         mem_pc           <= ex_pc;
         mem_rf_we        <= ex_rf_we;
         mem_rf_waddr     <= ex_rf_waddr;
         mem_alu_result   <= ex_alu_result;
         mem_res_from_mem <= ex_res_from_mem;
         mem_mem_req      <= ex_mem_req;
         mem_addr_lo      <= ex_addr_lo;
         mem_ld_b         <= ex_ld_b;
         mem_ld_h         <= ex_ld_h;
         mem_ld_u         <= ex_ld_u;
         mem_excep_en     <= ex_excep_en;
         mem_ertn_flush   <= ex_ertn_flush;
         mem_side         <= ex_side;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rbuf_valid <= 1'b0;
         rbuf_data  <= '0;
      end else if (flush || leave) begin
         rbuf_valid <= 1'b0;
      end else if (rbuf_set) begin
         rbuf_valid <= 1'b1;
         rbuf_data  <= data_sram_rdata;
      end
   end

   always_comb begin
      disc_cnt_d = disc_cnt;
      if (disc_inc && !disc_dec && disc_cnt != DiscMax) begin
         disc_cnt_d = disc_cnt + DISC_W'(1);
      end else if (disc_dec && !disc_inc) begin
         disc_cnt_d = disc_cnt - DISC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disc_cnt <= '0;
      end else begin
         disc_cnt <= disc_cnt_d;
      end
   end

   disc_sat_a: assert property (@(posedge clk) disable iff (!resetn)
      !(disc_inc && !disc_dec && disc_cnt == DiscMax));

   assign rdata_sel = rbuf_valid ? rbuf_data : data_sram_rdata;

   mem_load_align u_load_align (
      .rdata   (rdata_sel),
      .addr_lo (mem_addr_lo),
      .b       (mem_ld_b),
      .h       (mem_ld_h),
      .u       (mem_ld_u),
      .data    (load_data)
   );

   assign mem_final_result = mem_res_from_mem ? load_data : mem_alu_result;
   assign mem_fwd_we       = mem_valid & mem_rf_we;
   assign mem_fwd_waddr    = mem_rf_waddr;
   assign mem_fwd_data     = mem_final_result;
   assign mem_fwd_block    = mem_valid & mem_res_from_mem & ~ready_go;
   assign mem_to_ex_bus    = {mem_valid & mem_excep_en, mem_valid & mem_ertn_flush};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/flush/reset scenarios, then random traffic
// against a transaction-level model of the stage and the SRAM response stream.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int unsigned SW = 160;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          ex_to_mem_valid = 1'b0;
   logic          mem_allowin;
   logic [31:0]   ex_pc = '0;
   logic          ex_rf_we = 1'b0;
   logic [4:0]    ex_rf_waddr = '0;
   logic [31:0]   ex_alu_result = '0;
   logic          ex_res_from_mem = 1'b0;
   logic          ex_mem_req = 1'b0;
   logic [1:0]    ex_addr_lo = '0;
   logic          ex_ld_b = 1'b0, ex_ld_h = 1'b0, ex_ld_u = 1'b0;
   logic          ex_excep_en = 1'b0, ex_ertn_flush = 1'b0;
   logic [SW-1:0] ex_side = '0;
   logic          data_sram_data_ok = 1'b0;
   logic [31:0]   data_sram_rdata = '0;
   logic          flush = 1'b0;
   logic          wb_allowin = 1'b1;
   logic          mem_to_wb_valid;
   logic [31:0]   mem_pc;
   logic          mem_rf_we;
   logic [4:0]    mem_rf_waddr;
   logic [31:0]   mem_final_result;
   logic          mem_excep_en, mem_ertn_flush;
   logic [SW-1:0] mem_side;
   logic          mem_fwd_we;
   logic [4:0]    mem_fwd_waddr;
   logic [31:0]   mem_fwd_data;
   logic          mem_fwd_block;
   logic [1:0]    mem_to_ex_bus;

   mem_stage #(.SIDE_W(SW), .DISC_W(2)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .ex_to_mem_valid   (ex_to_mem_valid),
      .mem_allowin       (mem_allowin),
      .ex_pc             (ex_pc),
      .ex_rf_we          (ex_rf_we),
      .ex_rf_waddr       (ex_rf_waddr),
      .ex_alu_result     (ex_alu_result),
      .ex_res_from_mem   (ex_res_from_mem),
      .ex_mem_req        (ex_mem_req),
      .ex_addr_lo        (ex_addr_lo),
      .ex_ld_b           (ex_ld_b),
      .ex_ld_h           (ex_ld_h),
      .ex_ld_u           (ex_ld_u),
      .ex_excep_en       (ex_excep_en),
      .ex_ertn_flush     (ex_ertn_flush),
      .ex_side           (ex_side),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .flush             (flush),
      .wb_allowin        (wb_allowin),
      .mem_to_wb_valid   (mem_to_wb_valid),
      .mem_pc            (mem_pc),
      .mem_rf_we         (mem_rf_we),
      .mem_rf_waddr      (mem_rf_waddr),
      .mem_final_result  (mem_final_result),
      .mem_excep_en      (mem_excep_en),
      .mem_ertn_flush    (mem_ertn_flush),
      .mem_side          (mem_side),
      .mem_fwd_we        (mem_fwd_we),
      .mem_fwd_waddr     (mem_fwd_waddr),
      .mem_fwd_data      (mem_fwd_data),
      .mem_fwd_block     (mem_fwd_block),
      .mem_to_ex_bus     (mem_to_ex_bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model of the instruction held in the stage and of the response stream.
   typedef struct {
      logic [31:0]   pc;
      logic          we;
      logic [4:0]    waddr;
      logic [31:0]   alu;
      logic          ld;
      logic          req;
      logic [1:0]    lo;
      logic          b, h, u;
      logic          exc, ertn;
      logic [SW-1:0] side;
   } pl_t;

   pl_t         p;
   bit          mv, hd;
   logic [31:0] bd;
   int          stale, outstanding;

   function automatic logic [31:0] ld_ext(input logic [31:0] d, input logic [1:0] lo,
                                          input logic b, input logic h, input logic u);
      logic [31:0] s, v;
      s = d >> (8 * lo);
      if (b) begin
         v = s % 256;
         if (!u && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (h) begin
         v = s % 65536;
         if (!u && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = s;
      end
      return v;
   endfunction

   task automatic model_reset();
      mv = 0; hd = 0; bd = '0; stale = 0; outstanding = 0;
      p = '{pc: '0, we: 0, waddr: '0, alu: '0, ld: 0, req: 0, lo: '0, b: 0, h: 0, u: 0,
            exc: 0, ertn: 0, side: '0};
   endtask

   // Called with inputs already applied, between a negedge and the next posedge.
   task automatic step();
      bit          own, need, done, allow, leave;
      int          st0;
      logic [31:0] res;
      #1;
      own   = data_sram_data_ok && stale == 0;
      need  = mv && p.req && !hd;
      done  = !need || own;
      allow = !mv || (done && wb_allowin);
      leave = mv && done && wb_allowin;
      res   = p.ld ? ld_ext(hd ? bd : data_sram_rdata, p.lo, p.b, p.h, p.u) : p.alu;
      check_eq("allowin", mem_allowin, allow);
      check_eq("to_wb", mem_to_wb_valid, mv && done && !flush);
      check_eq("result", mem_final_result, res);
      check_eq("fwd_data", mem_fwd_data, res);
      check_eq("fwd_block", mem_fwd_block, mv && p.ld && !done);
      check_eq("fwd_we", mem_fwd_we, mv && p.we);
      check_eq("to_ex", mem_to_ex_bus, {mv && p.exc, mv && p.ertn});
      check_eq("disc_cnt", dut.disc_cnt, stale);
      if (mv) begin
         check_eq("pc", mem_pc, p.pc);
         check_eq("waddr", mem_fwd_waddr, p.waddr);
         check_eq("side", mem_side, p.side);
         check_eq("excep", {mem_excep_en, mem_ertn_flush, mem_rf_we}, {p.exc, p.ertn, p.we});
      end
      st0 = stale;
      if (flush && need && !own) stale++;
      if (data_sram_data_ok && st0 > 0) stale--;
      if (data_sram_data_ok) outstanding--;
      if (flush) begin
         mv = 0; hd = 0;
      end else begin
         if (need && own && !wb_allowin) begin
            hd = 1; bd = data_sram_rdata;
         end
         if (leave) hd = 0;
         if (allow) mv = ex_to_mem_valid;
      end
      if (allow && ex_to_mem_valid) begin
         p = '{pc: ex_pc, we: ex_rf_we, waddr: ex_rf_waddr, alu: ex_alu_result,
               ld: ex_res_from_mem, req: ex_mem_req, lo: ex_addr_lo, b: ex_ld_b, h: ex_ld_h,
               u: ex_ld_u, exc: ex_excep_en, ertn: ex_ertn_flush, side: ex_side};
         if (ex_mem_req && !flush) outstanding++;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic set_idle();
      ex_to_mem_valid = 0; ex_mem_req = 0; ex_res_from_mem = 0;
      ex_excep_en = 0; ex_ertn_flush = 0;
      data_sram_data_ok = 0; data_sram_rdata = $urandom; flush = 0; wb_allowin = 1;
   endtask

   task automatic set_load(input logic [1:0] lo, input logic b, input logic h, input logic u);
      set_idle();
      ex_to_mem_valid = 1; ex_pc = $urandom; ex_rf_we = 1; ex_rf_waddr = 5'($urandom);
      ex_alu_result = $urandom; ex_res_from_mem = 1; ex_mem_req = 1;
      ex_addr_lo = lo; ex_ld_b = b; ex_ld_h = h; ex_ld_u = u;
      ex_side = {$urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   // Load enters, waits one cycle, then its response arrives.
   task automatic run_load(input string tag, input logic [1:0] lo, input logic b, input logic h,
                           input logic u, input logic [31:0] rd, input logic [31:0] exp);
      set_load(lo, b, h, u);
      step();
      set_idle();
      #1;
      check_eq({tag, "_block"}, mem_fwd_block, 1'b1);
      step();
      set_idle();
      data_sram_data_ok = 1; data_sram_rdata = rd;
      #1;
      check_eq({tag, "_val"}, mem_final_result, exp);
      check_eq({tag, "_wb"}, mem_to_wb_valid, 1'b1);
      step();
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_allowin", mem_allowin, 1'b1);
      check_eq("rst_to_wb", mem_to_wb_valid, 1'b0);
      check_eq("rst_pc", mem_pc, '0);
      check_eq("rst_result", mem_final_result, '0);
      check_eq("rst_flags", {mem_rf_we, mem_rf_waddr, mem_excep_en, mem_ertn_flush}, '0);
      check_eq("rst_side", mem_side, '0);
      check_eq("rst_fwd", {mem_fwd_we, mem_fwd_waddr, mem_fwd_data, mem_fwd_block}, '0);
      check_eq("rst_to_ex", mem_to_ex_bus, '0);
      check_eq("rst_disc", dut.disc_cnt, '0);
   endtask

   task automatic rand_inputs();
      int sz;
      flush           = ($urandom % 12) == 0;
      ex_to_mem_valid = !flush && ($urandom % 2 == 0);
      ex_pc           = $urandom;
      ex_rf_we        = 1'($urandom);
      ex_rf_waddr     = 5'($urandom);
      ex_alu_result   = $urandom;
      sz              = int'($urandom % 3);
      ex_ld_b         = sz == 1;
      ex_ld_h         = sz == 2;
      ex_ld_u         = 1'($urandom);
      ex_addr_lo      = sz == 1 ? 2'($urandom) : (sz == 2 ? {1'($urandom), 1'b0} : 2'b00);
      ex_excep_en     = ($urandom % 8) == 0;
      ex_ertn_flush   = !ex_excep_en && ($urandom % 16) == 0;
      ex_res_from_mem = !ex_excep_en && !ex_ertn_flush && ($urandom % 2 == 0);
      ex_mem_req      = !ex_excep_en && !ex_ertn_flush && outstanding < 2 &&
                        (ex_res_from_mem || ($urandom % 3 == 0));
      ex_side         = {$urandom, $urandom, $urandom, $urandom, $urandom};
      data_sram_data_ok = outstanding > 0 && ($urandom % 3 != 0);
      data_sram_rdata = $urandom;
      wb_allowin      = ($urandom % 10) < 7;
   endtask

   initial begin
      model_reset();
      #2;
      check_reset_outputs();
      @(negedge clk);
      resetn = 1;
      #1;

      run_load("ldw", 2'd0, 0, 0, 0, 32'h89AB_CDEF, 32'h89AB_CDEF);
      run_load("ldb", 2'd3, 1, 0, 0, 32'h8011_2233, 32'hFFFF_FF80);
      run_load("ldbu", 2'd3, 1, 0, 1, 32'h8011_2233, 32'h0000_0080);
      run_load("ldh", 2'd2, 0, 1, 0, 32'h8011_2233, 32'hFFFF_8011);

      // Response arrives while writeback stalls; the buffered copy must win.
      set_load(2'd0, 0, 0, 0);
      step();
      set_idle();
      wb_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h1234;
      step();
      for (int i = 0; i < 2; i++) begin
         set_idle();
         wb_allowin = 0;
         step();
      end
      set_idle();
      data_sram_rdata = 32'hFFFF_FFFF;
      #1;
      check_eq("buf_val", mem_final_result, 32'h1234);
      check_eq("buf_wb", mem_to_wb_valid, 1'b1);
      step();

      // Flush a waiting load, then the next load must skip the stale response.
      set_load(2'd0, 0, 0, 0);
      step();
      set_idle();
      flush = 1;
      step();
      set_load(2'd0, 0, 0, 0);
      #1;
      check_eq("disc_after_flush", dut.disc_cnt, 2'd1);
      step();
      set_idle();
      data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD;
      #1;
      check_eq("stale_wb", mem_to_wb_valid, 1'b0);
      check_eq("stale_block", mem_fwd_block, 1'b1);
      step();
      set_idle();
      data_sram_data_ok = 1; data_sram_rdata = 32'hBEEF;
      #1;
      check_eq("own_val", mem_final_result, 32'hBEEF);
      check_eq("own_wb", mem_to_wb_valid, 1'b1);
      check_eq("own_disc", dut.disc_cnt, 2'd0);
      step();

      // Flush coincident with the response: nothing left to discard.
      set_load(2'd0, 0, 0, 0);
      step();
      set_idle();
      flush = 1; data_sram_data_ok = 1;
      #1;
      check_eq("flush_ok_wb", mem_to_wb_valid, 1'b0);
      step();
      set_idle();
      #1;
      check_eq("flush_ok_disc", dut.disc_cnt, 2'd0);

      // Exception passes straight through.
      set_idle();
      ex_to_mem_valid = 1; ex_excep_en = 1;
      step();
      set_idle();
      #1;
      check_eq("exc_bus", mem_to_ex_bus, 2'b10);
      check_eq("exc_wb", mem_to_wb_valid, 1'b1);
      step();

      // Reset while a new load waits behind one stale response.
      set_load(2'd0, 0, 0, 0);
      step();
      set_idle();
      flush = 1;
      step();
      set_load(2'd0, 0, 0, 0);
      step();
      set_idle();
      check_eq("pre_rst_disc", dut.disc_cnt, 2'd1);
      resetn = 0;
      #1;
      check_reset_outputs();
      model_reset();
      @(negedge clk);
      resetn = 1;
      #1;

      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
